// File: rtl/raster_pixel_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : raster_pixel_streamer_if
// Purpose  : Pixel stream handshake between the raster frame source and the
//            3x3 window generator (valid/ready with frame/line tags).
// Revision : 1.0 - initial release
// ============================================================================
interface raster_pixel_streamer_if;
  logic        per_clken;   // pixel valid
  logic [15:0] per_img_Y;   // pixel value
  logic        per_sof;     // first pixel of frame
  logic        per_eol;     // last pixel of a line
  logic        out_ready;   // sink accepts this cycle

  modport master (output per_clken, per_img_Y, per_sof, per_eol, input out_ready);
  modport slave  (input per_clken, per_img_Y, per_sof, per_eol, output out_ready);
endinterface
`default_nettype wire

// File: rtl/raster_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module   : raster_pixel_streamer
// Purpose  : Reads one IMG_W x IMG_H frame in raster order from a
//            synchronous-read memory, streams it with backpressure through a
//            2-entry skid FIFO, then appends FLUSH_PIX zero pixels.
// Revision : 1.0 - initial release
// ============================================================================
module raster_pixel_streamer #(
  parameter int IMG_W     = 512,
  parameter int IMG_H     = 636,
  parameter int ADDR_W    = 19,
  parameter int FLUSH_PIX = IMG_W + 2
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_start,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic                   o_mem_rd_en,
  output logic [ADDR_W-1:0]      o_mem_rd_addr,
  input  wire logic [15:0]       i_mem_rd_data,
  raster_pixel_streamer_if.master pix
);

  localparam int c_COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int c_FLUSH_W = (FLUSH_PIX > 0) ? $clog2(FLUSH_PIX + 1) : 1;
  localparam logic [c_COL_W-1:0]   c_COL_LAST   = c_COL_W'(IMG_W - 1);
  localparam logic [c_ROW_W-1:0]   c_ROW_LAST   = c_ROW_W'(IMG_H - 1);
  localparam logic [c_FLUSH_W-1:0] c_FLUSH_LAST = c_FLUSH_W'((FLUSH_PIX > 0) ? FLUSH_PIX - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  // Issue side: address and raster position of the next read.
  logic [ADDR_W-1:0]    r_rd_addr;
  logic [c_COL_W-1:0]   r_col;
  logic [c_ROW_W-1:0]   r_row;
  logic                 r_rd_done;

  // Read in flight and its tag {last, sof, eol}.
  logic                 r_inflight;
  logic [2:0]           r_inflight_tag;

  // Skid FIFO entries: {last, sof, eol, data}.
  logic [18:0]          r_fifo [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_cnt;

  logic [c_FLUSH_W-1:0] r_flush_cnt;

  logic [18:0]          w_head;
  logic                 w_pop;
  logic                 w_flush_acc;
  logic [2:0]           w_committed;
  logic                 w_issue;
  logic                 w_sof;
  logic                 w_eol;
  logic                 w_last;

  assign w_head      = r_fifo[r_rd_ptr];
  assign w_pop       = (r_state == S_READ) && (r_cnt != 2'd0) && pix.out_ready;
  assign w_flush_acc = (r_state == S_FLUSH) && pix.out_ready;

  // Slots already claimed once this cycle's pop is taken into account; a
  // pop frees a slot in time for a read issued now, which keeps 1 pixel/clk.
  assign w_committed = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

  // The first read goes out in the start cycle so the first pixel is ready
  // two cycles after start.
  assign w_issue = ((r_state == S_IDLE) && i_start) ||
                   ((r_state == S_READ) && !r_rd_done && (w_committed < 3'd2));

  assign w_sof  = (r_col == '0) && (r_row == '0);
  assign w_eol  = (r_col == c_COL_LAST);
  assign w_last = w_eol && (r_row == c_ROW_LAST);

  assign o_mem_rd_en   = w_issue;
  assign o_mem_rd_addr = r_rd_addr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt   = r_state;
    o_busy        = 1'b1;
    o_frame_done  = 1'b0;
    pix.per_clken = 1'b0;
    pix.per_img_Y = 16'h0000;
    pix.per_sof   = 1'b0;
    pix.per_eol   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_state_nxt = S_READ;
      end
      S_READ: begin
        pix.per_clken = (r_cnt != 2'd0);
        if (r_cnt != 2'd0) begin
          pix.per_img_Y = w_head[15:0];
          pix.per_sof   = w_head[17];
          pix.per_eol   = w_head[16];
        end
        if (w_pop && w_head[18]) begin
          if (FLUSH_PIX == 0) w_state_nxt = S_DONE;
          else                w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        pix.per_clken = 1'b1;
        if (w_flush_acc && (r_flush_cnt == c_FLUSH_LAST)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_frame_done = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read address / raster position; stops at the last frame pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_rd_done <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_rd_addr <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_rd_done <= 1'b0;
    end else if (w_issue) begin
      if (w_last) begin
        r_rd_done <= 1'b1;
      end else begin
        r_rd_addr <= r_rd_addr + 1'b1;
        if (w_eol) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Capture returning read data with its tag into the skid FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight     <= 1'b0;
      r_inflight_tag <= 3'b000;
      r_fifo[0]      <= '0;
      r_fifo[1]      <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_cnt          <= 2'd0;
    end else begin
      r_inflight     <= w_issue;
      r_inflight_tag <= {w_last, w_sof, w_eol};
      if (r_inflight) begin
        r_fifo[r_wr_ptr] <= {r_inflight_tag, i_mem_rd_data};
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({r_inflight, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Count accepted flush pixels; cleared while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_flush_cnt <= '0;
    else if (r_state == S_IDLE)   r_flush_cnt <= '0;
    else if (w_flush_acc)         r_flush_cnt <= r_flush_cnt + 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_raster_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_raster_pixel_streamer
// Purpose  : Self-checking bench: expected pixel records queued on each
//            accepted start, compared as the DUT hands pixels downstream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raster_pixel_streamer;

  typedef struct packed {
    logic        frame;
    logic        sof;
    logic        eol;
    logic [15:0] y;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, busy, frame_done, mem_rd_en;
  logic [3:0]  mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        out_ready;

  logic        start0, busy0, frame_done0, mem_rd_en0;
  logic [3:0]  mem_rd_addr0;
  logic [15:0] mem_rd_data0;

  raster_pixel_streamer_if pix ();
  raster_pixel_streamer_if pix0 ();
  assign pix.out_ready  = out_ready;
  assign pix0.out_ready = 1'b1;

  raster_pixel_streamer #(.IMG_W(4), .IMG_H(3), .ADDR_W(4), .FLUSH_PIX(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .o_busy(busy), .o_frame_done(frame_done),
    .o_mem_rd_en(mem_rd_en), .o_mem_rd_addr(mem_rd_addr), .i_mem_rd_data(mem_rd_data),
    .pix(pix.master));

  raster_pixel_streamer #(.IMG_W(4), .IMG_H(3), .ADDR_W(4), .FLUSH_PIX(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(start0), .o_busy(busy0), .o_frame_done(frame_done0),
    .o_mem_rd_en(mem_rd_en0), .o_mem_rd_addr(mem_rd_addr0), .i_mem_rd_data(mem_rd_data0),
    .pix(pix0.master));

  always #5 clk = ~clk;

  // Frame memories: mem[a] = 0x0100 + a, one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en)  mem_rd_data  <= 16'h0100 + {12'h000, mem_rd_addr};
    if (mem_rd_en0) mem_rd_data0 <= 16'h0100 + {12'h000, mem_rd_addr0};
  end

  int   n_vec = 0, n_err = 0;
  int   cyc = 0, start_cyc = 0, first_cyc = -1, done_cyc = 0, last_acc_cyc = 0;
  int   n_rd = 0, n_acc = 0, n_done = 0;
  logic prev_stall = 1'b0;
  logic [17:0] prev_pix;
  vec_t vec [14];
  vec_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    n_vec++;
    if (act > lim) begin
      n_err++;
      $display("FAIL %s: got %0d, expected at most %0d (t=%0t)", name, act, lim, $time);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_flags"}, {28'h0, busy, frame_done, mem_rd_en, pix.per_clken}, 32'h0);
    check({name, "_pix"}, {14'h0, pix.per_sof, pix.per_eol, pix.per_img_Y}, 32'h0);
  endtask

  // Scoreboard / protocol monitor for the FLUSH_PIX=2 instance.
  always @(negedge clk) begin
    vec_t e;
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (start && !busy) begin
        start_cyc = cyc;
        first_cyc = -1;
        n_rd      = 0;
        n_acc     = 0;
        for (int i = 0; i < 14; i++) exp_q.push_back(vec[i]);
      end
      if (pix.per_clken && first_cyc < 0) first_cyc = cyc;
      if (prev_stall)
        check("stall_hold", {14'h0, pix.per_clken, pix.per_sof, pix.per_eol, pix.per_img_Y},
              {14'h0, 1'b1, prev_pix});
      if (pix.per_clken && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", {16'h0, pix.per_img_Y}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pixel", {14'h0, pix.per_sof, pix.per_eol, pix.per_img_Y}, {14'h0, e.sof, e.eol, e.y});
          if (e.frame) n_acc++;
        end
        last_acc_cyc = cyc;
      end
      if (mem_rd_en) begin
        n_rd++;
        check_le("rd_addr_range", int'(mem_rd_addr), 11);
        check_le("reads_ahead", n_rd - n_acc, 2);
      end
      if (frame_done) begin
        n_done++;
        done_cyc = cyc;
        check("done_q_empty", exp_q.size(), 0);
        check("done_after_last", cyc, last_acc_cyc + 1);
      end
      prev_stall = pix.per_clken && !out_ready;
      prev_pix   = {pix.per_sof, pix.per_eol, pix.per_img_Y};
    end
  end

  // mode 0: ready=1, 1: random ready, 2: 10-cycle stall on first pixel,
  // 3: ready=1 with start pulsed mid-frame and in the done cycle.
  task automatic run_frame(input int mode);
    bit got = 1'b0;
    int stall_left = 10;
    out_ready = (mode != 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (frame_done) begin
        got = 1'b1;
        if (mode == 3) start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: if (first_cyc >= 0) begin
             if (stall_left > 0) begin
               stall_left--;
               if (stall_left == 5) begin
                 check("stall_clken", pix.per_clken, 1);
                 check("stall_y", pix.per_img_Y, 16'h0100);
               end
             end else begin
               out_ready = 1'b1;
             end
           end
        3: if (c == 6) start = 1'b1;
        default: out_ready = 1'b1;
      endcase
    end
    check("frame_timeout", got, 1);
    if (got) check("busy_after_done", busy, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    int d0, k, done_at;
    for (int i = 0; i < 14; i++) begin
      vec[i].frame = (i < 12);
      vec[i].sof   = (i == 0);
      vec[i].eol   = (i < 12) && (i % 4 == 3);
      vec[i].y     = (i < 12) ? 16'(16'h0100 + i) : 16'h0000;
    end
    rst_n = 1'b0; start = 1'b0; start0 = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_idle("idle");

    // 1: back-to-back frame
    run_frame(0);
    check("t1_first_lat", first_cyc - start_cyc, 2);
    check("t1_done_lat", done_cyc - start_cyc, 16);

    // 2: random backpressure
    run_frame(1);
    run_frame(1);

    // 3: long stall on first pixel
    run_frame(2);

    // 4: spurious starts mid-frame and in done cycle
    d0 = n_done;
    run_frame(3);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t4_busy_low", {busy, pix.per_clken}, 2'b00);
    end
    check("t4_single_done", n_done, d0 + 1);

    // 5: async reset mid-frame
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && n_acc < 6; c++) begin
      @(posedge clk); #1;
    end
    check("t5_reached_px6", n_acc >= 6, 1);
    #2 rst_n = 1'b0;
    #1 check_idle("t5_in_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 check_idle("t5_in_reset2");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(0);
    check("t5_first_lat", first_cyc - start_cyc, 2);

    // 6: FLUSH_PIX=0 instance, hand-checked sequence
    k = 0; done_at = -1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (pix0.per_clken) begin
        check("t6_pixel", {14'h0, pix0.per_sof, pix0.per_eol, pix0.per_img_Y},
              {14'h0, 1'(k == 0), 1'(k % 4 == 3), 16'(16'h0100 + k)});
        k++;
      end
      if (frame_done0) done_at = c;
    end
    check("t6_count", k, 12);
    check("t6_done_lat", done_at, 14);
    check("t6_busy_low", busy0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
